immu_tlb_lookup: RTL and testbench

- 16-entry fully associative instruction TLB array with a registered lookup pipeline.
- Sits directly upstream of the IMMU hit/permission judge. On each fetch request it selects the matching entry and presents V/TS/TID/EPN/PERMIS (plus RPN/WIMGE) to the judge one cycle later.
- Also services tlbwe-style writes from the MAS registers, MMUCSR0 flash invalidate, and maintains the round-robin next-victim (NV) pointer.

---
 rtl/immu_tlb_lookup.sv | 148 ++++++++++++++
 tb/tb_immu_tlb_lookup.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/immu_tlb_lookup.sv
// Fully associative instruction TLB with a one-cycle registered lookup.
// Handles MAS writes, flash invalidate and the round-robin next-victim pointer.
module immu_tlb_lookup #(
    parameter int NENTRY = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lk_req,
    input  logic [19:0]     lk_ea_epn,
    input  logic            lk_as,
    input  logic [7:0]      pid0,
    input  logic [7:0]      pid1,
    input  logic [7:0]      pid2,
    output logic            rsp_valid,
    output logic            rsp_hit,
    output logic            rsp_multi,
    output logic [IDXW-1:0] rsp_idx,
    output logic            rsp_v,
    output logic            rsp_ts,
    output logic [7:0]      rsp_tid,
    output logic [19:0]     rsp_epn,
    output logic [19:0]     rsp_rpn,
    output logic [4:0]      rsp_wimge,
    output logic [5:0]      rsp_permis,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_esel,
    input  logic            wr_v,
    input  logic            wr_iprot,
    input  logic [7:0]      wr_tid,
    input  logic            wr_ts,
    input  logic [19:0]     wr_epn,
    input  logic [4:0]      wr_wimge,
    input  logic [19:0]     wr_rpn,
    input  logic [5:0]      wr_permis,
    input  logic            flash_inv,
    output logic [IDXW-1:0] nv
);

    logic [NENTRY-1:0] r_v;
    logic [NENTRY-1:0] r_iprot;
    logic [NENTRY-1:0] r_ts;
    logic [7:0]        r_tid    [NENTRY];
    logic [19:0]       r_epn    [NENTRY];
    logic [19:0]       r_rpn    [NENTRY];
    logic [4:0]        r_wimge  [NENTRY];
    logic [5:0]        r_permis [NENTRY];

    logic [NENTRY-1:0] w_match;
    logic [IDXW-1:0]   w_sel;
    logic              w_hit;
    logic              w_multi;

    // Tag compare of every entry against the incoming fetch
    always_comb begin
        w_match = '0;
        for (int i = 0; i < NENTRY; i++) begin
            w_match[i] = r_v[i] && (r_ts[i] == lk_as) && (r_epn[i] == lk_ea_epn) &&
                         ((r_tid[i] == 8'h00) || (r_tid[i] == pid0) ||
                          (r_tid[i] == pid1)  || (r_tid[i] == pid2));
        end
    end

    // Lowest matching index wins; clearing the lowest set bit exposes a second match
    always_comb begin
        w_sel = '0;
        for (int i = NENTRY - 1; i >= 0; i--) begin
            w_sel = w_match[i] ? IDXW'(i) : w_sel;
        end
        w_hit   = |w_match;
        w_multi = |(w_match & (w_match - NENTRY'(1)));
    end

    // Lookup result register; fields hold when no request, zero on a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_multi  <= 1'b0;
            rsp_idx    <= '0;
            rsp_v      <= 1'b0;
            rsp_ts     <= 1'b0;
            rsp_tid    <= 8'h00;
            rsp_epn    <= 20'h00000;
            rsp_rpn    <= 20'h00000;
            rsp_wimge  <= 5'h00;
            rsp_permis <= 6'h00;
        end else if (lk_req) begin
            rsp_valid  <= 1'b1;
            rsp_hit    <= w_hit;
            rsp_multi  <= w_multi;
            rsp_idx    <= w_sel;
            rsp_v      <= w_hit ? r_v[w_sel]      : 1'b0;
            rsp_ts     <= w_hit ? r_ts[w_sel]     : 1'b0;
            rsp_tid    <= w_hit ? r_tid[w_sel]    : 8'h00;
            rsp_epn    <= w_hit ? r_epn[w_sel]    : 20'h00000;
            rsp_rpn    <= w_hit ? r_rpn[w_sel]    : 20'h00000;
            rsp_wimge  <= w_hit ? r_wimge[w_sel]  : 5'h00;
            rsp_permis <= w_hit ? r_permis[w_sel] : 6'h00;
        end else begin
            rsp_valid  <= 1'b0;
        end
    end

    // Entry array: flash clears unprotected V first, a same-cycle write then overrides
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v     <= '0;
            r_iprot <= '0;
            r_ts    <= '0;
            for (int i = 0; i < NENTRY; i++) begin
                r_tid[i]    <= 8'h00;
                r_epn[i]    <= 20'h00000;
                r_rpn[i]    <= 20'h00000;
                r_wimge[i]  <= 5'h00;
                r_permis[i] <= 6'h00;
            end
        end else begin
            for (int i = 0; i < NENTRY; i++) begin
                if (flash_inv && !r_iprot[i]) begin
                    r_v[i] <= 1'b0;
                end
                if (wr_en && (wr_esel == IDXW'(i))) begin
                    r_v[i]      <= wr_v;
                    r_iprot[i]  <= wr_iprot;
                    r_ts[i]     <= wr_ts;
                    r_tid[i]    <= wr_tid;
                    r_epn[i]    <= wr_epn;
                    r_rpn[i]    <= wr_rpn;
                    r_wimge[i]  <= wr_wimge;
                    r_permis[i] <= wr_permis;
                end
            end
        end
    end

    // Next-victim pointer advances only when the victim itself is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nv <= '0;
        end else if (wr_en && (wr_esel == nv)) begin
            nv <= nv + IDXW'(1);
        end else begin
            nv <= nv;
        end
    end

endmodule

// File: tb/tb_immu_tlb_lookup.sv
// Self-checking bench for immu_tlb_lookup: directed scenarios plus random
// traffic compared against a behavioural TLB model.
module tb_immu_tlb_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_req;
    logic [19:0] lk_ea_epn;
    logic        lk_as;
    logic [7:0]  pid0, pid1, pid2;
    logic        rsp_valid, rsp_hit, rsp_multi;
    logic [3:0]  rsp_idx;
    logic        rsp_v, rsp_ts;
    logic [7:0]  rsp_tid;
    logic [19:0] rsp_epn, rsp_rpn;
    logic [4:0]  rsp_wimge;
    logic [5:0]  rsp_permis;
    logic        wr_en;
    logic [3:0]  wr_esel;
    logic        wr_v, wr_iprot, wr_ts;
    logic [7:0]  wr_tid;
    logic [19:0] wr_epn, wr_rpn;
    logic [4:0]  wr_wimge;
    logic [5:0]  wr_permis;
    logic        flash_inv;
    logic [3:0]  nv;

    immu_tlb_lookup #(.NENTRY(16), .IDXW(4)) dut (
        .clk(clk), .rst(rst), .lk_req(lk_req), .lk_ea_epn(lk_ea_epn), .lk_as(lk_as),
        .pid0(pid0), .pid1(pid1), .pid2(pid2),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_multi(rsp_multi), .rsp_idx(rsp_idx),
        .rsp_v(rsp_v), .rsp_ts(rsp_ts), .rsp_tid(rsp_tid), .rsp_epn(rsp_epn),
        .rsp_rpn(rsp_rpn), .rsp_wimge(rsp_wimge), .rsp_permis(rsp_permis),
        .wr_en(wr_en), .wr_esel(wr_esel), .wr_v(wr_v), .wr_iprot(wr_iprot),
        .wr_tid(wr_tid), .wr_ts(wr_ts), .wr_epn(wr_epn), .wr_wimge(wr_wimge),
        .wr_rpn(wr_rpn), .wr_permis(wr_permis), .flash_inv(flash_inv), .nv(nv)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        iprot;
        logic        ts;
        logic [7:0]  tid;
        logic [19:0] epn;
        logic [19:0] rpn;
        logic [4:0]  wimge;
        logic [5:0]  permis;
    } ent_t;

    ent_t m_tlb [16];
    int   m_nv;
    logic e_valid, e_hit, e_multi;
    int   e_idx;
    ent_t e_ent;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("valid", 32'(rsp_valid), 32'(e_valid));
        check_eq("hit", 32'(rsp_hit), 32'(e_hit));
        check_eq("multi", 32'(rsp_multi), 32'(e_multi));
        check_eq("idx", 32'(rsp_idx), 32'(e_idx));
        check_eq("v", 32'(rsp_v), 32'(e_ent.v));
        check_eq("ts", 32'(rsp_ts), 32'(e_ent.ts));
        check_eq("tid", 32'(rsp_tid), 32'(e_ent.tid));
        check_eq("epn", 32'(rsp_epn), 32'(e_ent.epn));
        check_eq("rpn", 32'(rsp_rpn), 32'(e_ent.rpn));
        check_eq("wimge", 32'(rsp_wimge), 32'(e_ent.wimge));
        check_eq("permis", 32'(rsp_permis), 32'(e_ent.permis));
        check_eq("nv", 32'(nv), 32'(m_nv));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tlb[i] = '0;
        m_nv = 0; e_valid = 1'b0; e_hit = 1'b0; e_multi = 1'b0; e_idx = 0; e_ent = '0;
    endtask

    // One clock: predict from the pre-edge table, update the table, then compare.
    task automatic cycle();
        int cnt;
        if (lk_req) begin
            cnt = 0; e_idx = 0; e_ent = '0;
            for (int i = 0; i < 16; i++) begin
                if (m_tlb[i].v && m_tlb[i].ts == lk_as && m_tlb[i].epn == lk_ea_epn &&
                    (m_tlb[i].tid == 8'h00 || m_tlb[i].tid == pid0 ||
                     m_tlb[i].tid == pid1 || m_tlb[i].tid == pid2)) begin
                    if (cnt == 0) begin
                        e_idx = i;
                        e_ent = m_tlb[i];
                    end
                    cnt++;
                end
            end
            e_valid = 1'b1; e_hit = (cnt > 0); e_multi = (cnt > 1);
        end else begin
            e_valid = 1'b0;
        end
        if (flash_inv)
            for (int i = 0; i < 16; i++)
                if (!m_tlb[i].iprot) m_tlb[i].v = 1'b0;
        if (wr_en) begin
            m_tlb[wr_esel] = '{v: wr_v, iprot: wr_iprot, ts: wr_ts, tid: wr_tid, epn: wr_epn,
                               rpn: wr_rpn, wimge: wr_wimge, permis: wr_permis};
            if (int'(wr_esel) == m_nv) m_nv = (m_nv + 1) % 16;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        lk_req = 1'b0; wr_en = 1'b0; flash_inv = 1'b0;
    endtask

    task automatic set_write(input int esel, input logic v, input logic iprot, input logic [7:0] tid,
                             input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] permis);
        wr_en = 1'b1; wr_esel = 4'(esel); wr_v = v; wr_iprot = iprot; wr_tid = tid;
        wr_ts = 1'b0; wr_epn = epn; wr_rpn = rpn; wr_permis = permis; wr_wimge = 5'($urandom);
    endtask

    task automatic do_write(input int esel, input logic v, input logic iprot, input logic [7:0] tid,
                            input logic [19:0] epn, input logic [19:0] rpn, input logic [5:0] permis);
        set_write(esel, v, iprot, tid, epn, rpn, permis);
        cycle();
        idle();
    endtask

    task automatic do_lookup(input logic [19:0] epn, input logic as_bit);
        lk_req = 1'b1; lk_ea_epn = epn; lk_as = as_bit;
        cycle();
        idle();
    endtask

    int start_nv;

    initial begin
        rst = 1'b1;
        idle();
        lk_ea_epn = 20'h00000; lk_as = 1'b0; pid0 = 8'h01; pid1 = 8'h05; pid2 = 8'h02;
        wr_esel = 4'h0; wr_v = 1'b0; wr_iprot = 1'b0; wr_tid = 8'h00; wr_ts = 1'b0;
        wr_epn = 20'h00000; wr_wimge = 5'h00; wr_rpn = 20'h00000; wr_permis = 6'h00;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        do_lookup(20'h00010, 1'b0);
        check_eq("tp_empty_valid", 32'(rsp_valid), 32'd1);
        check_eq("tp_empty_hit", 32'(rsp_hit), 32'd0);

        do_write(3, 1'b1, 1'b0, 8'h05, 20'h00010, 20'hABCDE, 6'b110000);
        do_lookup(20'h00010, 1'b0);
        check_eq("tp_pid1_hit", 32'(rsp_hit), 32'd1);
        check_eq("tp_pid1_idx", 32'(rsp_idx), 32'd3);
        check_eq("tp_pid1_rpn", 32'(rsp_rpn), 32'hABCDE);
        pid0 = 8'h07; pid1 = 8'h07; pid2 = 8'h07;
        do_lookup(20'h00010, 1'b0);
        check_eq("tp_pid_miss", 32'(rsp_hit), 32'd0);

        do_write(2, 1'b1, 1'b0, 8'h00, 20'h00020, 20'h11111, 6'b000011);
        do_write(9, 1'b1, 1'b0, 8'h00, 20'h00020, 20'h22222, 6'b000011);
        do_lookup(20'h00020, 1'b0);
        check_eq("tp_multi", 32'(rsp_multi), 32'd1);
        check_eq("tp_multi_idx", 32'(rsp_idx), 32'd2);

        do_write(4, 1'b1, 1'b1, 8'h00, 20'h00040, 20'h44444, 6'b111111);
        do_write(5, 1'b1, 1'b0, 8'h00, 20'h00050, 20'h55555, 6'b111111);
        flash_inv = 1'b1; cycle(); idle();
        do_lookup(20'h00040, 1'b0);
        check_eq("tp_iprot_keep", 32'(rsp_hit), 32'd1);
        do_lookup(20'h00050, 1'b0);
        check_eq("tp_flash_clear", 32'(rsp_hit), 32'd0);
        flash_inv = 1'b1;
        set_write(6, 1'b1, 1'b0, 8'h00, 20'h00060, 20'h66666, 6'b010101);
        cycle(); idle();
        do_lookup(20'h00060, 1'b0);
        check_eq("tp_flash_wr", 32'(rsp_hit), 32'd1);

        set_write(7, 1'b1, 1'b0, 8'h00, 20'h00070, 20'h77777, 6'b100001);
        lk_req = 1'b1; lk_ea_epn = 20'h00070; lk_as = 1'b0;
        cycle(); idle();
        check_eq("tp_same_cyc_miss", 32'(rsp_hit), 32'd0);
        lk_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("tp_b2b_valid", 32'(rsp_valid), 32'd1);
            check_eq("tp_next_hit", 32'(rsp_hit), 32'd1);
        end
        idle();

        for (int k = 0; k < 4; k++) begin
            do_write(0, 1'b1, 1'b0, 8'h00, 20'h00080, 20'h88888, 6'b000001);
            check_eq("tp_nv_esel0", 32'(nv), 32'd1);
        end
        start_nv = m_nv;
        for (int k = 0; k < 16; k++)
            do_write((start_nv + k) % 16, 1'b1, 1'b0, 8'h00, 20'(32'h100 + k), 20'(k), 6'b000001);
        check_eq("tp_nv_wrap", 32'(nv), 32'(start_nv));

        for (int k = 0; k < 400; k++) begin
            lk_req    = ($urandom_range(0, 2) != 0);
            lk_ea_epn = 20'(32'h10 * $urandom_range(1, 4));
            lk_as     = 1'($urandom_range(0, 1));
            pid0 = 8'h05; pid1 = ($urandom_range(0, 1) != 0) ? 8'h07 : 8'h03; pid2 = 8'(8'h09 * $urandom_range(0, 1));
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_esel   = 4'($urandom);
            wr_v      = ($urandom_range(0, 3) != 0);
            wr_iprot  = 1'($urandom_range(0, 1));
            wr_ts     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       wr_tid = 8'h00;
                1:       wr_tid = 8'h05;
                2:       wr_tid = 8'h07;
                default: wr_tid = 8'h0B;
            endcase
            wr_epn    = 20'(32'h10 * $urandom_range(1, 4));
            wr_rpn    = 20'($urandom);
            wr_wimge  = 5'($urandom);
            wr_permis = 6'($urandom);
            flash_inv = ($urandom_range(0, 24) == 0);
            cycle();
        end
        idle();

        do_write(1, 1'b1, 1'b1, 8'h00, 20'h00090, 20'h99999, 6'b000001);
        lk_req = 1'b1; lk_ea_epn = 20'h00090; lk_as = 1'b0;
        cycle();
        check_eq("tp_pre_rst_hit", 32'(rsp_hit), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        lk_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check_eq("tp_post_rst_valid", 32'(rsp_valid), 32'd0);
        do_lookup(20'h00090, 1'b0);
        check_eq("tp_post_rst_miss", 32'(rsp_hit), 32'd0);
        do_lookup(20'h00040, 1'b0);
        do_lookup(20'h00020, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
